uart_tx_fifo_8n1: RTL



---
 rtl/crg_uart_pkg.sv | 8 +
 rtl/sync_fifo.sv | 45 ++++
 rtl/uart_tx_fifo_8n1.sv | 80 ++++++++
 3 files changed

// File: rtl/crg_uart_pkg.sv
// crg_uart_pkg: shared types and helpers for the CRG UART transmit and receive paths
package crg_uart_pkg;
  localparam int UART_DATA_W = 8;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock circular-buffer FIFO with occupancy count
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("sync_fifo DEPTH must be a power of two >= 2");
  end
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign full_o  = cnt_q == FULL_CNT;
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= do_push ? wr_q + 1'b1 : wr_q;
      rd_q  <= do_pop ? rd_q + 1'b1 : rd_q;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart_tx_fifo_8n1.sv
// uart_tx_fifo_8n1: FIFO-buffered 8N1 UART transmitter fed by a valid/ready byte stream
module uart_tx_fifo_8n1
  import crg_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [UART_DATA_W-1:0]      tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int unsigned CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned CW  = $clog2(CPB);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_MAX = CW'(CPB - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  uart_tx_state_t state_q;
  logic [CW-1:0] baud_q;
  logic [2:0] bit_q;
  logic [UART_DATA_W-1:0] shift_q, fifo_dout;
  logic txd_q, ready_q, fifo_full, fifo_empty, push, pop, baud_end;
  logic [AW:0] count_d;
  if (CPB < 4) begin : g_cpb_chk
    $error("CLKS_PER_BIT must be at least 4");
  end
  sync_fifo #(.WIDTH(UART_DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (tx_data),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );
  assign push     = tx_valid & ready_q & ~fifo_full;
  assign baud_end = baud_q == BAUD_MAX;
  // Loading from STOP's last cycle chains frames with no idle gap
  assign pop      = ~fifo_empty & (state_q == IDLE | (state_q == STOP & baud_end));
  assign count_d  = fifo_count + (AW+1)'(push) - (AW+1)'(pop);
  assign tx_ready = ready_q;
  assign txd      = txd_q;
  assign busy     = state_q != IDLE | fifo_count != '0;
  // txd is registered from the current state, so the whole frame trails the FSM by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      ready_q <= count_d != FULL_CNT;
      txd_q   <= state_q == START ? 1'b0 : state_q == DATA ? shift_q[bit_q] : 1'b1;
      baud_q  <= (state_q == IDLE || baud_end) ? '0 : baud_q + 1'b1;
      if (pop) begin
        shift_q <= fifo_dout;
        bit_q   <= '0;
        state_q <= START;
      end else if (state_q != IDLE && baud_end) begin
        case (state_q)
          START: state_q <= DATA;
          DATA: begin
            bit_q   <= bit_q + 1'b1;
            state_q <= bit_q == 3'd7 ? STOP : DATA;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule
